// File: rtl/wb_buffer_arbiter.sv
// wb_buffer_arbiter: I/D-cache to memory arbiter with a one-entry write-back buffer.
module wb_buffer_arbiter #(
  parameter int DRAIN_LIMIT = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read_c_i,
  input  logic [31:0]  pmem_address_c_i,
  output logic [255:0] pmem_rdata_c_i,
  output logic         pmem_resp_c_i,
  input  logic         pmem_read_c_d,
  input  logic         pmem_write_c_d,
  input  logic [31:0]  pmem_address_c_d,
  input  logic [255:0] pmem_wdata_c_d,
  output logic [255:0] pmem_rdata_c_d,
  output logic         pmem_resp_c_d,
  output logic         pmem_read_m,
  output logic         pmem_write_m,
  output logic [31:0]  pmem_address_m,
  output logic [255:0] pmem_wdata_m,
  input  logic [255:0] pmem_rdata_m,
  input  logic         pmem_resp_m
);
  localparam int CW = $clog2(DRAIN_LIMIT + 1);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] MEM_I   = 3'd1;
  localparam logic [2:0] MEM_D   = 3'd2;
  localparam logic [2:0] MEM_WB  = 3'd3;
  localparam logic [2:0] BUF_HIT = 3'd4;
  localparam logic [2:0] WB_ACK  = 3'd5;
  logic [2:0]    state, next, pick;
  logic          buf_valid;
  logic [31:0]   buf_addr;
  logic [255:0]  buf_data;
  logic [CW-1:0] starve_cnt;
  logic          rd_d, match_d, match_i, starved, mem_busy, read_grant;
  // a simultaneous read and write from the D-cache is treated as a write
  assign rd_d     = pmem_read_c_d & ~pmem_write_c_d;
  assign match_d  = buf_valid & (pmem_address_c_d[31:OFFSET_BITS] == buf_addr[31:OFFSET_BITS]);
  assign match_i  = buf_valid & (pmem_address_c_i[31:OFFSET_BITS] == buf_addr[31:OFFSET_BITS]);
  assign starved  = buf_valid & (starve_cnt == CW'(DRAIN_LIMIT));
  assign mem_busy = (state == MEM_I) | (state == MEM_D) | (state == MEM_WB);
  always_comb begin
    pick = (buf_valid & pmem_write_c_d) ? MEM_WB :
           (rd_d & match_d)             ? BUF_HIT :
           pmem_write_c_d               ? WB_ACK :
           starved                      ? MEM_WB :
           rd_d                         ? MEM_D :
           (pmem_read_c_i & match_i)    ? MEM_WB :
           pmem_read_c_i                ? MEM_I :
           buf_valid                    ? MEM_WB : IDLE;
    next = (state == IDLE) ? pick : (mem_busy & ~pmem_resp_m) ? state : IDLE;
  end
  assign read_grant = (state == IDLE) & ((next == MEM_D) | (next == MEM_I));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      starve_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next == WB_ACK) begin
        buf_valid <= 1'b1;
        buf_addr  <= {pmem_address_c_d[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        buf_data  <= pmem_wdata_c_d;
      end else if (state == MEM_WB && pmem_resp_m) begin
        buf_valid <= 1'b0;
      end
      if (!buf_valid || (state == MEM_WB && pmem_resp_m))
        starve_cnt <= '0;
      else if (read_grant && starve_cnt != CW'(DRAIN_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
  assign pmem_read_m    = (state == MEM_D) | (state == MEM_I);
  assign pmem_write_m   = state == MEM_WB;
  assign pmem_address_m = (state == MEM_D)  ? pmem_address_c_d :
                          (state == MEM_I)  ? pmem_address_c_i :
                          (state == MEM_WB) ? buf_addr : '0;
  assign pmem_wdata_m   = pmem_write_m ? buf_data : '0;
  assign pmem_resp_c_i  = (state == MEM_I) & pmem_resp_m;
  assign pmem_rdata_c_i = pmem_resp_c_i ? pmem_rdata_m : '0;
  assign pmem_resp_c_d  = (state == WB_ACK) | (state == BUF_HIT) | ((state == MEM_D) & pmem_resp_m);
  assign pmem_rdata_c_d = (state == BUF_HIT) ? buf_data :
                          ((state == MEM_D) & pmem_resp_m) ? pmem_rdata_m : '0;
endmodule

// File: tb/tb_wb_buffer_arbiter.sv
// tb_wb_buffer_arbiter: directed and random checks of the write-back buffer arbiter
// against a coherent-memory reference and a latency-randomised adaptor model.
module tb_wb_buffer_arbiter;
  localparam int DL = 4;
  logic         clk, rst;
  logic         pmem_read_c_i;
  logic [31:0]  pmem_address_c_i;
  logic [255:0] pmem_rdata_c_i;
  logic         pmem_resp_c_i;
  logic         pmem_read_c_d, pmem_write_c_d;
  logic [31:0]  pmem_address_c_d;
  logic [255:0] pmem_wdata_c_d, pmem_rdata_c_d;
  logic         pmem_resp_c_d;
  logic         pmem_read_m, pmem_write_m;
  logic [31:0]  pmem_address_m;
  logic [255:0] pmem_wdata_m, pmem_rdata_m;
  logic         pmem_resp_m;

  wb_buffer_arbiter #(.DRAIN_LIMIT(DL), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .pmem_read_c_i(pmem_read_c_i), .pmem_address_c_i(pmem_address_c_i),
    .pmem_rdata_c_i(pmem_rdata_c_i), .pmem_resp_c_i(pmem_resp_c_i),
    .pmem_read_c_d(pmem_read_c_d), .pmem_write_c_d(pmem_write_c_d),
    .pmem_address_c_d(pmem_address_c_d), .pmem_wdata_c_d(pmem_wdata_c_d),
    .pmem_rdata_c_d(pmem_rdata_c_d), .pmem_resp_c_d(pmem_resp_c_d),
    .pmem_read_m(pmem_read_m), .pmem_write_m(pmem_write_m),
    .pmem_address_m(pmem_address_m), .pmem_wdata_m(pmem_wdata_m),
    .pmem_rdata_m(pmem_rdata_m), .pmem_resp_m(pmem_resp_m)
  );

  typedef struct {logic w; logic [31:0] a; logic [255:0] d;} txn_t;
  txn_t         log_q[$];
  logic [255:0] ref_mem [logic [26:0]];
  logic [255:0] mem [logic [26:0]];
  logic [31:0]  pool [6] = '{32'h1000, 32'h1020, 32'h2000, 32'h3040, 32'h8000, 32'h8020};
  int           total = 0, passed = 0;
  bit           pending = 0, stall = 0;
  int           starve_run = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [255:0] init_line(input logic [26:0] t);
    logic [31:0] w;
    w = ({5'd0, t} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return {8{w}};
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    return ref_mem.exists(a[31:5]) ? ref_mem[a[31:5]] : init_line(a[31:5]);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    return mem.exists(a[31:5]) ? mem[a[31:5]] : init_line(a[31:5]);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Memory side: logs every command, answers after 0-2 extra cycles unless stalled or reset.
  initial begin
    pmem_resp_m = 0;
    pmem_rdata_m = '0;
    forever begin
      @(negedge clk);
      if (!rst && (pmem_read_m || pmem_write_m)) begin
        txn_t t;
        int n;
        t.w = pmem_write_m;
        t.a = pmem_address_m;
        t.d = pmem_wdata_m;
        log_q.push_back(t);
        if (!t.w && pending) begin
          starve_run++;
          check("starve_bound", starve_run <= DL, 1);
        end
        n = $urandom_range(0, 2);
        while ((n > 0 || stall) && !rst) begin
          @(negedge clk);
          if (n > 0) n--;
        end
        if (!rst) begin
          @(posedge clk); #1;
          check("hold_addr", pmem_address_m, t.a);
          check("hold_cmd", {pmem_write_m, pmem_read_m}, {t.w, !t.w});
          if (t.w) begin
            check("drain_data", t.d, ref_line(t.a));
            mem[t.a[31:5]] = t.d;
            pending = 0;
            starve_run = 0;
          end else pmem_rdata_m = mem_line(t.a);
          pmem_resp_m = 1;
          @(posedge clk); #1;
          pmem_resp_m = 0;
          pmem_rdata_m = '0;
        end
      end
    end
  end

  task automatic d_req(input logic w, input logic [31:0] a, input logic [255:0] wd,
                       output logic [255:0] rd, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0;
    @(posedge clk); #1;
    pmem_write_c_d = w;
    pmem_read_c_d = !w;
    pmem_address_c_d = a;
    pmem_wdata_c_d = w ? wd : '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (pmem_resp_c_d) begin got = 1; rd = pmem_rdata_c_d; end
      else lat++;
    end
    check("d_resp", got, 1);
    if (got && w) begin
      ref_mem[a[31:5]] = wd;
      pending = 1;
    end else if (got) check("d_rdata", rd, ref_line(a));
  endtask

  task automatic d_release();
    @(posedge clk); #1;
    pmem_read_c_d = 0;
    pmem_write_c_d = 0;
  endtask

  task automatic i_req(input logic [31:0] a, output logic [255:0] rd, output int lat);
    bit got;
    got = 0; lat = 0; rd = '0;
    @(posedge clk); #1;
    pmem_read_c_i = 1;
    pmem_address_c_i = a;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (pmem_resp_c_i) begin got = 1; rd = pmem_rdata_c_i; end
      else lat++;
    end
    check("i_resp", got, 1);
    if (got) check("i_rdata", rd, ref_line(a));
    @(posedge clk); #1;
    pmem_read_c_i = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pending || pmem_write_m) && n < 200) begin @(negedge clk); n++; end
    check("drain_done", pending, 0);
  endtask

  task automatic expect_txn(input string tag, input logic w, input logic [31:0] a, input logic [255:0] d);
    txn_t t;
    check({tag, "_present"}, log_q.size() > 0, 1);
    if (log_q.size() > 0) begin
      t = log_q.pop_front();
      check({tag, "_cmd"}, t.w, w);
      check({tag, "_addr"}, t.a, a);
      if (w) check({tag, "_data"}, t.d, d);
    end
  endtask

  initial begin
    logic [255:0] rd, rd2, da, db;
    int lat, lat2, n;
    rst = 1;
    pmem_read_c_i = 0; pmem_address_c_i = '0;
    pmem_read_c_d = 0; pmem_write_c_d = 0; pmem_address_c_d = '0; pmem_wdata_c_d = '0;
    repeat (2) @(negedge clk);
    check("rst_read_m", pmem_read_m, 0);
    check("rst_write_m", pmem_write_m, 0);
    check("rst_addr_m", pmem_address_m, 0);
    check("rst_resp_i", pmem_resp_c_i, 0);
    check("rst_resp_d", pmem_resp_c_d, 0);
    check("rst_rdata_d", pmem_rdata_c_d, 0);
    @(posedge clk); #1;
    rst = 0;

    // eviction acks in one cycle, drains once idle
    da = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    check("t1_lat", lat, 1);
    check("t1_quiet", log_q.size(), 0);
    d_release();
    wait_drain();
    expect_txn("t1_drain", 1, 32'h1040, da);
    @(negedge clk);
    check("t1_rdata_i_idle", pmem_rdata_c_i, 0);
    check("t1_rdata_d_idle", pmem_rdata_c_d, 0);

    // D read hitting the buffered line
    da = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    d_req(0, 32'h1048, '0, rd, lat);
    check("t2_lat", lat, 1);
    check("t2_data", rd, da);
    check("t2_no_mem", log_q.size(), 0);
    d_release();
    wait_drain();
    expect_txn("t2_drain", 1, 32'h1040, da);

    // D before I before drain
    da = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    fork
      begin d_req(0, 32'h3000, '0, rd, lat); d_release(); end
      begin i_req(32'h2000, rd2, lat2); end
    join
    wait_drain();
    expect_txn("t3_first", 0, 32'h3000, '0);
    expect_txn("t3_second", 0, 32'h2000, '0);
    expect_txn("t3_drain", 1, 32'h1040, da);

    // forced drain after DL bypassing grants
    da = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    for (int k = 0; k < 6; k++) d_req(0, 32'h6000 + 32'(k * 32), '0, rd, lat);
    d_release();
    wait_drain();
    for (int k = 0; k < 4; k++) expect_txn("t4_read", 0, 32'h6000 + 32'(k * 32), '0);
    expect_txn("t4_forced_drain", 1, 32'h1040, da);
    expect_txn("t4_resume0", 0, 32'h6080, '0);
    expect_txn("t4_resume1", 0, 32'h60A0, '0);

    // second eviction waits for the first to drain
    da = rand_line();
    db = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    d_req(1, 32'h5000, db, rd, lat);
    check("t5_drained_first", log_q.size(), 1);
    expect_txn("t5_drain", 1, 32'h1040, da);
    d_req(0, 32'h5010, '0, rd, lat);
    check("t5_hit_data", rd, db);
    check("t5_hit_lat", lat, 1);
    check("t5_no_mem", log_q.size(), 0);
    d_release();
    wait_drain();
    expect_txn("t5_final", 1, 32'h5000, db);

    // reset while the drain is outstanding
    da = rand_line();
    d_req(1, 32'h1040, da, rd, lat);
    stall = 1;
    d_release();
    n = 0;
    while (!pmem_write_m && n < 50) begin @(negedge clk); n++; end
    check("t6_in_wb", pmem_write_m, 1);
    rst = 1;
    #1;
    check("t6_write_m", pmem_write_m, 0);
    check("t6_read_m", pmem_read_m, 0);
    check("t6_resp_d", pmem_resp_c_d, 0);
    check("t6_resp_i", pmem_resp_c_i, 0);
    ref_mem.delete(27'(32'h1040 >> 5));
    pending = 0;
    starve_run = 0;
    stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    log_q.delete();
    repeat (4) @(negedge clk);
    check("t6_buf_discarded", log_q.size(), 0);
    i_req(32'h2000, rd, lat);
    expect_txn("t6_iread", 0, 32'h2000, '0);

    // random traffic over a small set of lines
    log_q.delete();
    for (int k = 0; k < 200; k++) begin
      int op;
      logic [31:0] a1, a2;
      op = $urandom_range(0, 4);
      a1 = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31));
      a2 = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 31));
      if (op == 0) d_req(1, a1, rand_line(), rd, lat);
      else if (op == 1) d_req(0, a1, '0, rd, lat);
      else if (op == 2) begin d_release(); i_req(a2, rd, lat); end
      else fork
        begin d_req(op == 4, a1, rand_line(), rd, lat); d_release(); end
        begin i_req(a2, rd2, lat2); end
      join
      if ($urandom_range(0, 2) == 0) begin
        d_release();
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    end
    d_release();
    wait_drain();
    log_q.delete();
    for (int j = 0; j < 6; j++) check("mem_image", mem_line(pool[j]), ref_line(pool[j]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
